// File: rtl/csr_bank.sv
// Control/status register bank: host req/ack access to RW config registers,
// RO status sampling, and a sticky edge-captured maskable interrupt block.

module csr_cfg_reg #(
    parameter int              REG_W = 8,
    parameter logic [REG_W-1:0] RST  = '0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             we,
    input  logic [REG_W-1:0] wdata,
    output logic [REG_W-1:0] q
);
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)   q <= RST;
        else if (we) q <= wdata;
    end
endmodule

module csr_bank #(
    parameter int                          REG_W      = 8,
    parameter int                          ADDR_W     = 8,
    parameter int                          NUM_CFG    = 8,
    parameter int                          NUM_STATUS = 8,
    parameter int                          NUM_IRQ    = 8,
    parameter logic [NUM_CFG*REG_W-1:0]    CFG_RESET  = '0
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic                          req,
    input  logic                          wr_rdn,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [REG_W-1:0]              wdata,
    output logic [REG_W-1:0]              rdata,
    output logic                          ack,
    output logic                          err,
    output logic [NUM_CFG*REG_W-1:0]      rw_regs,
    input  logic [NUM_STATUS*REG_W-1:0]   ro_regs,
    input  logic [NUM_IRQ-1:0]            irq_src,
    output logic                          irq
);
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  wdata;
    } csr_req_t;

    csr_req_t                             hreq;
    logic                                 acc;
    logic [31:0]                          idx;
    logic                                 hi_region;
    logic                                 cfg_hit, st_hit, irqst_hit, mask_hit;
    logic [NUM_CFG-1:0][REG_W-1:0]        cfg_q;
    logic [NUM_STATUS-1:0][REG_W-1:0]     st_in;
    logic [REG_W-1:0]                     rd_val;
    logic                                 rd_err;
    logic [NUM_IRQ-1:0]                   irq_st, irq_mask, irq_prev;
    logic [NUM_IRQ-1:0]                   new_set, clr;

    assign hreq      = '{wr: wr_rdn, addr: addr, wdata: wdata};
    assign acc       = ena & req;
    assign idx       = 32'(hreq.addr[ADDR_W-2:0]);
    assign hi_region = hreq.addr[ADDR_W-1];
    assign cfg_hit   = !hi_region && (idx < 32'(NUM_CFG));
    assign st_hit    = hi_region && (idx < 32'(NUM_STATUS));
    assign irqst_hit = hi_region && (idx == 32'(NUM_STATUS));
    assign mask_hit  = hi_region && (idx == 32'(NUM_STATUS + 1));
    assign st_in     = ro_regs;
    assign rw_regs   = cfg_q;

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
        csr_cfg_reg #(
            .REG_W (REG_W),
            .RST   (CFG_RESET[k*REG_W +: REG_W])
        ) u_reg (
            .clk   (clk),
            .rstb  (rstb),
            .we    (acc && hreq.wr && cfg_hit && (idx == 32'(k))),
            .wdata (hreq.wdata),
            .q     (cfg_q[k])
        );
    end

    // Decode is shared by reads and writes; only status writes differ in error.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (cfg_hit) begin
            for (int k = 0; k < NUM_CFG; k++)
                if (idx == 32'(k)) rd_val = cfg_q[k];
        end else if (st_hit) begin
            for (int k = 0; k < NUM_STATUS; k++)
                if (idx == 32'(k)) rd_val = st_in[k];
            rd_err = hreq.wr;
        end else if (irqst_hit) begin
            rd_val = REG_W'(irq_st);
        end else if (mask_hit) begin
            rd_val = REG_W'(irq_mask);
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= acc;
            if (acc) begin
                err   <= rd_err;
                rdata <= hreq.wr ? '0 : rd_val;
            end
        end
    end

    assign new_set = irq_src & ~irq_prev;
    assign clr     = (acc && hreq.wr && irqst_hit) ? hreq.wdata[NUM_IRQ-1:0] : '0;

    // irq follows the registered status/mask, so it lags a status change by one edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            irq_prev <= '0;
            irq_st   <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            irq_prev <= irq_src;
            irq_st   <= (irq_st & ~clr) | new_set;
            if (acc && hreq.wr && mask_hit) irq_mask <= hreq.wdata[NUM_IRQ-1:0];
            irq <= |(irq_st & irq_mask);
        end
    end
endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: reset image, config RW, decode errors,
// status sampling, sticky interrupts, enable gating and async reset.

module tb_csr_bank;
    localparam int REG_W = 8, ADDR_W = 8, NUM_CFG = 5, NUM_STATUS = 8, NUM_IRQ = 8;
    localparam logic [NUM_CFG*REG_W-1:0] CFG_RST = 40'h00_00_A5_00_00;

    logic                         clk = 1'b0;
    logic                         rstb, ena, req, wr_rdn;
    logic [ADDR_W-1:0]            addr;
    logic [REG_W-1:0]             wdata, rdata;
    logic                         ack, err, irq;
    logic [NUM_CFG*REG_W-1:0]     rw_regs;
    logic [NUM_STATUS*REG_W-1:0]  ro_regs;
    logic [NUM_IRQ-1:0]           irq_src;
    int                           passed = 0, total = 0;

    csr_bank #(
        .REG_W(REG_W), .ADDR_W(ADDR_W), .NUM_CFG(NUM_CFG),
        .NUM_STATUS(NUM_STATUS), .NUM_IRQ(NUM_IRQ), .CFG_RESET(CFG_RST)
    ) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .req(req), .wr_rdn(wr_rdn),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
        .rw_regs(rw_regs), .ro_regs(ro_regs), .irq_src(irq_src), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        req = r; wr_rdn = w; addr = a; wdata = d;
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; irq_src = '0; ro_regs = '0;
        drive(0, 0, 8'h00, 8'h00);
        #12;
        chk("rst_cfg",   rw_regs, 40'h00_00_A5_00_00);
        chk("rst_ack",   ack, 0);
        chk("rst_err",   err, 0);
        chk("rst_irq",   irq, 0);
        chk("rst_rdata", rdata, 0);
        rstb = 1'b1;
        step();

        // config write then back-to-back read
        drive(1, 1, 8'h03, 8'h3C); step();
        chk("wr_ack",   ack, 1);
        chk("wr_err",   err, 0);
        chk("wr_rdata", rdata, 0);
        chk("wr_reg3",  rw_regs[31:24], 8'h3C);
        drive(1, 0, 8'h03, 8'h00); step();
        chk("rd_ack",   ack, 1);
        chk("rd_rdata", rdata, 8'h3C);
        chk("rd_err",   err, 0);
        drive(0, 0, 8'h00, 8'h00); step();
        chk("idle_ack",  ack, 0);
        chk("hold_data", rdata, 8'h3C);

        // unmapped config read, write to RO status
        drive(1, 0, 8'h05, 8'h00); step();
        chk("unm_ack",   ack, 1);
        chk("unm_err",   err, 1);
        chk("unm_rdata", rdata, 0);
        drive(1, 1, 8'h80, 8'hFF); step();
        chk("rowr_ack", ack, 1);
        chk("rowr_err", err, 1);
        drive(0, 0, 8'h00, 8'h00); step();
        chk("rowr_cfg", rw_regs, 40'h00_3C_A5_00_00);
        chk("rowr_in",  ro_regs, 64'h0);

        // status sample
        ro_regs = 64'h0000_0000_0000_7700;
        drive(1, 0, 8'h81, 8'h00); step();
        chk("st_rdata", rdata, 8'h77);
        chk("st_err",   err, 0);
        drive(1, 0, 8'h80, 8'h00); step();
        chk("st0_rdata", rdata, 8'h00);

        // mask then source pulse
        drive(1, 1, 8'h89, 8'h01); step();
        chk("mask_err", err, 0);
        drive(1, 0, 8'h89, 8'h00); step();
        chk("mask_rd", rdata, 8'h01);
        drive(0, 0, 8'h00, 8'h00);
        irq_src = 8'h01; step();
        chk("irq_lag", irq, 0);
        irq_src = 8'h00; step();
        chk("irq_set", irq, 1);
        drive(1, 0, 8'h88, 8'h00); step();
        chk("ist_rd", rdata, 8'h01);
        drive(1, 1, 8'h88, 8'h01); step();
        chk("clr_irq_hold", irq, 1);
        drive(0, 0, 8'h00, 8'h00); step();
        chk("clr_irq_fall", irq, 0);
        drive(1, 0, 8'h88, 8'h00); step();
        chk("clr_ist", rdata, 8'h00);

        // set wins over clear; held source does not re-set
        irq_src = 8'h01;
        drive(1, 1, 8'h88, 8'h01); step();
        drive(1, 0, 8'h88, 8'h00); step();
        chk("set_wins", rdata, 8'h01);
        drive(1, 1, 8'h88, 8'h01); step();
        drive(1, 0, 8'h88, 8'h00); step();
        chk("held_src", rdata, 8'h00);
        drive(0, 0, 8'h00, 8'h00); irq_src = 8'h00; step();

        // enable gating
        ena = 1'b0;
        drive(1, 1, 8'h00, 8'h55); step();
        chk("ena_ack", ack, 0);
        chk("ena_reg", rw_regs[7:0], 8'h00);
        ena = 1'b1;

        // async reset in the ack cycle
        drive(1, 1, 8'h00, 8'h5A); step();
        chk("pre_rst_ack", ack, 1);
        drive(0, 0, 8'h00, 8'h00);
        #1 rstb = 1'b0;
        #1;
        chk("arst_ack", ack, 0);
        chk("arst_cfg", rw_regs, 40'h00_00_A5_00_00);
        #1 rstb = 1'b1;
        step();
        drive(1, 0, 8'h89, 8'h00); step();
        chk("arst_mask", rdata, 8'h00);
        drive(0, 0, 8'h00, 8'h00); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
